regwr_arbiter: RTL and testbench

REGWR_ARBITER -- requirements
Module: regwr_arbiter

---
 rtl/regwr_arbiter.sv | 87 ++++++++
 tb/tb_regwr_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: merges ALU and load writebacks into one register-file write port
//   clock, reset            : clock, asynchronous active-high reset
//   alu_valid/alu_ready     : ALU writeback handshake, alu_reg_num/alu_dat payload
//   mem_valid/mem_ready     : load writeback handshake, mem_reg_num/mem_dat payload
//   Write_reg_num/Write_Dat : registered register-file write address/data
//   RegWriteout, grant_mem  : registered write enable and source of the current write
//   pending_mask            : registers with a nonzero-register write held or on the output
//   REGWR_ARB_RR_EN         : defined selects round-robin, undefined selects mem-over-alu priority
module regwr_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_reg_num,
  input  logic [31:0] alu_dat,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_reg_num,
  input  logic [31:0] mem_dat,
  output logic [4:0]  Write_reg_num,
  output logic [31:0] Write_Dat,
  output logic        RegWriteout,
  output logic        grant_mem,
  output logic [31:0] pending_mask
);
  logic        a_v, m_v, mem_first, fav_m, pick_m, win_m, win_a, acc_a, acc_m;
  logic [4:0]  a_r, m_r;
  logic [31:0] a_d, m_d;
  assign pick_m = (a_r == m_r && a_r != 5'd0) ? mem_first : fav_m;
  assign win_m = m_v & (~a_v | pick_m);
  assign win_a = a_v & ~win_m;
  assign alu_ready = ~a_v | win_a;
  assign mem_ready = ~m_v | win_m;
  assign acc_a = alu_valid & alu_ready;
  assign acc_m = mem_valid & mem_ready;
`ifdef REGWR_ARB_RR_EN
  logic ptr_m;
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr_m <= 1'b1;
    else if (a_v & m_v) ptr_m <= win_a;
  assign fav_m = ptr_m;
`else
  assign fav_m = 1'b1;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a_v <= 1'b0;
      m_v <= 1'b0;
      a_r <= '0;
      m_r <= '0;
      a_d <= '0;
      m_d <= '0;
      mem_first <= 1'b0;
      Write_reg_num <= '0;
      Write_Dat <= '0;
      RegWriteout <= 1'b0;
      grant_mem <= 1'b0;
    end else begin
      a_v <= acc_a | (a_v & ~win_a);
      m_v <= acc_m | (m_v & ~win_m);
      if (acc_a) begin
        a_r <= alu_reg_num;
        a_d <= alu_dat;
      end
      if (acc_m) begin
        m_r <= mem_reg_num;
        m_d <= mem_dat;
      end
      // a fresh ALU fill is never older than mem; a lone fresh mem fill is younger than a held ALU entry
      if (acc_a) mem_first <= 1'b1;
      else if (acc_m) mem_first <= 1'b0;
      RegWriteout <= 1'b0;
      if (win_m | win_a) begin
        Write_reg_num <= win_m ? m_r : a_r;
        Write_Dat <= win_m ? m_d : a_d;
        grant_mem <= win_m;
        RegWriteout <= (win_m ? m_r : a_r) != 5'd0;
      end
    end
  always_comb begin
    pending_mask = '0;
    if (a_v) pending_mask[a_r] = 1'b1;
    if (m_v) pending_mask[m_r] = 1'b1;
    if (RegWriteout) pending_mask[Write_reg_num] = 1'b1;
    pending_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: randomized scoreboard bench for regwr_arbiter
module tb_regwr_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready, RegWriteout, grant_mem;
  logic [4:0]  alu_reg_num = '0, mem_reg_num = '0, Write_reg_num;
  logic [31:0] alu_dat = '0, mem_dat = '0, Write_Dat, pending_mask;
  always #5 clock = ~clock;
  regwr_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg_num(alu_reg_num), .alu_dat(alu_dat),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg_num(mem_reg_num), .mem_dat(mem_dat),
    .Write_reg_num(Write_reg_num), .Write_Dat(Write_Dat), .RegWriteout(RegWriteout),
    .grant_mem(grant_mem), .pending_mask(pending_mask)
  );
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic        m;
  } wr_t;
  wr_t exp_q[$];
  int vectors = 0, miscompares = 0;
  logic mon_en = 1'b0, exp_pulse = 1'b0;
  // reference model: each side holds at most one write stamped with the cycle it arrived
  logic        av = 1'b0, mv = 1'b0, fav_m = 1'b1, owen = 1'b0;
  logic [4:0]  ar = '0, mr = '0, orr = '0;
  logic [31:0] ad = '0, md = '0;
  int          at = 0, mt = 0, cyc = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clock)
    if (mon_en) begin
      chk("RegWriteout", {31'd0, RegWriteout}, {31'd0, exp_pulse});
      if (RegWriteout) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got r%0d=%h expected no write", Write_reg_num, Write_Dat);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("Write_reg_num", {27'd0, Write_reg_num}, {27'd0, w.r});
          chk("Write_Dat", Write_Dat, w.d);
          chk("grant_mem", {31'd0, grant_mem}, {31'd0, w.m});
        end
      end
    end
  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
  endfunction
  task automatic step(input int pct);
    logic pm, wm, wa, ra, rm, aa, am;
    logic [31:0] pend;
    wr_t w;
    @(negedge clock);
    #1;
    // older-wins for same nonzero register (mem older on a tie); otherwise the policy
    if (av && mv && ar == mr && ar != 5'd0) pm = (mt <= at);
`ifdef REGWR_ARB_RR_EN
    else pm = fav_m;
`else
    else pm = 1'b1;
`endif
    wm = mv && (!av || pm);
    wa = av && !wm;
    ra = !av || wa;
    rm = !mv || wm;
    pend = '0;
    if (av) pend[ar] = 1'b1;
    if (mv) pend[mr] = 1'b1;
    if (owen) pend[orr] = 1'b1;
    pend[0] = 1'b0;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ra});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, rm});
    chk("pending_mask", pending_mask, pend);
    alu_valid = $urandom_range(99) < pct;
    mem_valid = $urandom_range(99) < pct;
    alu_reg_num = rnd_reg();
    mem_reg_num = rnd_reg();
    alu_dat = $urandom;
    mem_dat = $urandom;
    aa = alu_valid && ra;
    am = mem_valid && rm;
    @(posedge clock);
    owen = 1'b0;
    if (wm || wa) begin
      w.r = wm ? mr : ar;
      w.d = wm ? md : ad;
      w.m = wm;
      orr = w.r;
      owen = w.r != 5'd0;
      if (owen) exp_q.push_back(w);
    end
    exp_pulse = owen;
    if (av && mv) fav_m = wa;
    if (aa) begin
      av = 1'b1; ar = alu_reg_num; ad = alu_dat; at = cyc;
    end else if (wa) av = 1'b0;
    if (am) begin
      mv = 1'b1; mr = mem_reg_num; md = mem_dat; mt = cyc;
    end else if (wm) mv = 1'b0;
    cyc++;
  endtask
  task automatic reset_checks();
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_pending_mask", pending_mask, 32'd0);
    chk("rst_RegWriteout", {31'd0, RegWriteout}, 32'd0);
  endtask
  initial begin
    @(negedge clock);
    #1;
    reset_checks();
    chk("rst_Write_reg_num", {27'd0, Write_reg_num}, 32'd0);
    chk("rst_Write_Dat", Write_Dat, 32'd0);
    chk("rst_grant_mem", {31'd0, grant_mem}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (300) step(60);
    repeat (100) step(100);
    repeat (4) step(0);
    repeat (20) step(100);
    @(negedge clock);
    #2;
    reset = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    reset_checks();
    av = 1'b0; mv = 1'b0; owen = 1'b0; exp_pulse = 1'b0; fav_m = 1'b1;
    exp_q.delete();
    @(negedge clock);
    #1;
    reset_checks();
    reset = 1'b0;
    repeat (5) step(0);
    repeat (300) step(75);
    repeat (6) step(0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
